// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative signed/unsigned multiply/divide with HI/LO registers.
// A start pulse in IDLE runs WIDTH shift steps, then a fix-up cycle writes hi/lo.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] write_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [2*WIDTH:0] r_acc, w_shl, w_step;
  logic [WIDTH-1:0] r_b, r_hi, r_lo, w_a_abs, w_b_abs, w_q, w_r, w_hi_res, w_lo_res;
  logic [2*WIDTH-1:0] w_prod, w_mres;
  logic [WIDTH:0] w_sum, w_diff;
  logic r_div, r_neg_a, r_neg_b, r_zero, r_done, w_signed, w_flip;
  assign w_signed = ~op[0];
  assign w_a_abs = (w_signed && in_1[WIDTH-1]) ? -in_1 : in_1;
  assign w_b_abs = (w_signed && in_2[WIDTH-1]) ? -in_2 : in_2;
  // Multiply keeps the carry in the guard bit; divide uses it as the remainder sign.
  assign w_sum = r_acc[2*WIDTH:WIDTH] + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_shl = {r_acc[2*WIDTH-1:0], 1'b0};
  assign w_diff = w_shl[2*WIDTH:WIDTH] - {1'b0, r_b};
  assign w_step = r_div ? (w_diff[WIDTH] ? w_shl : {w_diff, w_shl[WIDTH-1:1], 1'b1})
                        : {1'b0, w_sum, r_acc[WIDTH-1:1]};
  assign w_prod = r_acc[2*WIDTH-1:0];
  assign w_q = r_acc[WIDTH-1:0];
  assign w_r = r_acc[2*WIDTH-1:WIDTH];
  assign w_flip = r_neg_a ^ r_neg_b;
  assign w_mres = w_flip ? -w_prod : w_prod;
  // A zero divisor leaves the dividend magnitude as remainder, so the sign fix-up restores in_1.
  assign w_hi_res = r_div ? (r_neg_a ? -w_r : w_r) : w_mres[2*WIDTH-1:WIDTH];
  assign w_lo_res = r_div ? (r_zero ? '1 : (w_flip ? -w_q : w_q)) : w_mres[WIDTH-1:0];
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (start ? RUN : IDLE) :
             (r_state == RUN) ? ((r_cnt == '0) ? FINISH : RUN) : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_b <= '0;
      r_hi <= '0;
      r_lo <= '0;
      r_div <= 1'b0;
      r_neg_a <= 1'b0;
      r_neg_b <= 1'b0;
      r_zero <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == FINISH);
      if (r_state == IDLE) begin
        if (start) begin
          r_div <= op[1];
          r_neg_a <= w_signed & in_1[WIDTH-1];
          r_neg_b <= w_signed & in_2[WIDTH-1];
          r_zero <= (in_2 == '0);
          r_b <= w_b_abs;
          r_acc <= {{(WIDTH+1){1'b0}}, w_a_abs};
          r_cnt <= CW'(WIDTH-1);
        end else begin
          if (hi_we) r_hi <= write_data;
          if (lo_we) r_lo <= write_data;
        end
      end else if (r_state == RUN) begin
        r_acc <= w_step;
        if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
      end else begin
        r_hi <= w_hi_res;
        r_lo <= w_lo_res;
      end
    end
  end
  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign hi = r_hi;
  assign lo = r_lo;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: randomized scoreboard bench for mul_div_unit against a plain-arithmetic model.
module tb_mul_div_unit;
  logic clk = 1'b0, reset = 1'b1;
  logic start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [1:0] op = '0;
  logic [31:0] in_1 = '0, in_2 = '0, write_data = '0, hi, lo;
  logic busy, done;
  logic start8 = 1'b0;
  logic [7:0] hi8, lo8;
  logic busy8, done8;
  int cyc = 0, n_tests = 0, n_fail = 0;
  bit prev_done = 1'b0;
  typedef struct {logic [63:0] r; int c;} exp_t;
  exp_t q[$];

  mul_div_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .start(start), .op(op), .in_1(in_1),
    .in_2(in_2), .hi_we(hi_we), .lo_we(lo_we), .write_data(write_data), .busy(busy), .done(done),
    .hi(hi), .lo(lo));
  mul_div_unit #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .start(start8), .op(2'b01),
    .in_1(8'hFF), .in_2(8'hFF), .hi_we(1'b0), .lo_we(1'b0), .write_data(8'h00), .busy(busy8),
    .done(done8), .hi(hi8), .lo(lo8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o == 2'd0) return sa * sb;
    if (o == 2'd1) return {32'b0, a} * {32'b0, b};
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    if (o == 2'd2) return {32'(sa % sb), 32'(sa / sb)};
    return {a % b, a / b};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        chk("done_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          exp_t e;
          e = q.pop_front();
          chk("hi", hi, e.r[63:32]);
          chk("lo", lo, e.r[31:0]);
          chk("latency", cyc, e.c);
        end
        if (prev_done) chk("done_one_cycle", 0, 1);
      end
      prev_done = done;
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit inject);
    logic [31:0] h0, l0;
    bit held;
    @(posedge clk); #1;
    h0 = hi; l0 = lo; held = 1'b1;
    op = o; in_1 = a; in_2 = b; start = 1'b1;
    hi_we = inject; lo_we = inject; write_data = $urandom;
    q.push_back('{ref_model(o, a, b), cyc + 34});
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    for (int k = 0; k < 100 && busy; k++) begin
      if (busy && (hi !== h0 || lo !== l0)) held = 1'b0;
      if (inject && k == 5) begin
        start = 1'b1; op = ~o; in_1 = $urandom; hi_we = 1'b1; write_data = $urandom;
      end
      @(posedge clk); #1;
      start = 1'b0; hi_we = 1'b0;
    end
    chk("busy_clears", busy, 0);
    chk("hold_in_run", held, 1);
  endtask

  initial begin
    logic [31:0] l_keep;
    int c8;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    reset = 1'b0;
    issue(2'd0, 32'hFFFFFFFD, 32'd7, 1'b0);
    issue(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    issue(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    issue(2'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    issue(2'd3, 32'd100, 32'd7, 1'b0);
    issue(2'd3, 32'd100, 32'd0, 1'b0);
    issue(2'd2, 32'hFFFFFF9C, 32'd0, 1'b0);
    issue(2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    issue(2'd0, 32'h80000000, 32'h80000000, 1'b1);
    @(posedge clk); #1;
    l_keep = lo;
    hi_we = 1'b1; write_data = 32'h12345678;
    @(posedge clk); #1;
    hi_we = 1'b0;
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_lo", lo, l_keep);
    hi_we = 1'b1; lo_we = 1'b1; write_data = 32'hCAFEF00D;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    chk("both_hi", hi, 32'hCAFEF00D);
    chk("both_lo", lo, 32'hCAFEF00D);
    for (int i = 0; i < 40; i++)
      issue(2'($urandom_range(0, 3)), pick(), pick(), (i % 8) == 3);
    start8 = 1'b1;
    c8 = cyc;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int k = 0; k < 30 && !done8; k++) begin
      @(posedge clk); #1;
    end
    chk("w8_done", done8, 1);
    chk("w8_latency", cyc - c8, 10);
    chk("w8_hi", hi8, 8'hFE);
    chk("w8_lo", lo8, 8'h01);
    @(posedge clk); #1;
    op = 2'd0; in_1 = $urandom; in_2 = $urandom; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (45) @(posedge clk);
    issue(2'd3, 32'd100, 32'd7, 1'b0);
    issue(2'd0, pick(), pick(), 1'b0);
    repeat (4) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
